wakeup_ready_table: RTL

Registered, parametrised source-operand ready tracker for one issue queue. It replaces combinational tag compare with per-entry ready state, which fixes three gaps. It supports multiple wakeup ports with per-grant functional-unit latency (delayed broadcast). It snoops wakeups at dispatch, so entries allocated in the same cycle as a broadcast are not missed. It handles flush. It sits between the per-port arbiters, the dispatch stage and the issue-queue select logic.

---
 rtl/wake_pkg.sv | 22 ++
 rtl/wakeup_ready_table_if.sv | 42 ++++
 rtl/wakeup_delay_line.sv | 71 +++++++
 rtl/wakeup_ready_table.sv | 121 ++++++++++++
 4 files changed

// File: rtl/wake_pkg.sv
// Shared types and width helpers for the wakeup/ready tracking slice.
package wake_pkg;

    // Tag width baked into wk_tag_t; the top's PRF_WIDTH must equal it.
    localparam int WK_PRF_WIDTH = 6;

    typedef struct packed {
        logic                    valid;
        logic [WK_PRF_WIDTH-1:0] tag;
    } wk_tag_t;

    localparam logic [WK_PRF_WIDTH-1:0] TAG_ZERO = '0;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lat_width(input int max_lat);
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/wakeup_ready_table_if.sv
// Dispatch, wakeup, dequeue and ready-status bundle of the wakeup ready table.
interface wakeup_ready_table_if
    import wake_pkg::*;
#(
    parameter int ISSUE_NUM    = 4,
    parameter int DISPATCH_NUM = 4,
    parameter int PRF_WIDTH    = WK_PRF_WIDTH,
    parameter int CIQ_DEPTH    = 16,
    parameter int MAX_LAT      = 4
);
    localparam int IDX_W = idx_width(CIQ_DEPTH);
    localparam int LAT_W = lat_width(MAX_LAT);

    logic                                     flush;
    logic [ISSUE_NUM-1:0]                     wk_v;
    logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]      wk_prd;
    logic [ISSUE_NUM-1:0][LAT_W-1:0]          wk_lat;
    logic [DISPATCH_NUM-1:0]                  alloc_v;
    logic [DISPATCH_NUM-1:0][IDX_W-1:0]       alloc_idx;
    logic [DISPATCH_NUM-1:0][PRF_WIDTH-1:0]   alloc_prs1;
    logic [DISPATCH_NUM-1:0][PRF_WIDTH-1:0]   alloc_prs2;
    logic [DISPATCH_NUM-1:0]                  alloc_rdy1;
    logic [DISPATCH_NUM-1:0]                  alloc_rdy2;
    logic [CIQ_DEPTH-1:0]                     ent_clr;
    logic [CIQ_DEPTH-1:0]                     prs1_rdy;
    logic [CIQ_DEPTH-1:0]                     prs2_rdy;
    logic [CIQ_DEPTH-1:0]                     ent_rdy;
    logic                                     wk_collide;

    modport master (
        output flush, wk_v, wk_prd, wk_lat, alloc_v, alloc_idx, alloc_prs1, alloc_prs2,
               alloc_rdy1, alloc_rdy2, ent_clr,
        input  prs1_rdy, prs2_rdy, ent_rdy, wk_collide
    );

    modport slave (
        input  flush, wk_v, wk_prd, wk_lat, alloc_v, alloc_idx, alloc_prs1, alloc_prs2,
               alloc_rdy1, alloc_rdy2, ent_clr,
        output prs1_rdy, prs2_rdy, ent_rdy, wk_collide
    );

endinterface

// File: rtl/wakeup_delay_line.sv
// Per-port wakeup delay line: a grant of latency L appears on o_bcast L-1 cycles later
// (L=1 passes straight through); a grant aimed at an occupied slot is dropped.
module wakeup_delay_line
    import wake_pkg::*;
#(
    parameter int MAX_LAT = 4,
    parameter int LAT_W   = lat_width(MAX_LAT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_wk_v,
    input  logic [WK_PRF_WIDTH-1:0] i_wk_prd,
    input  logic [LAT_W-1:0]        i_wk_lat,
    output wk_tag_t                 o_bcast,
    output logic                    o_collide
);
    localparam int NSTG = MAX_LAT - 1;

    wk_tag_t          r_stage [NSTG];
    wk_tag_t          w_next  [NSTG];
    logic [LAT_W-1:0] w_lat;
    logic             w_occ;

    always_comb begin
        if (i_wk_lat == '0)                      w_lat = LAT_W'(1);
        else if (i_wk_lat > LAT_W'(MAX_LAT))     w_lat = LAT_W'(MAX_LAT);
        else                                     w_lat = i_wk_lat;
    end

    // Target slot after the shift holds today's stage L-1; for L=MAX_LAT it is always free.
    always_comb begin
        w_occ = 1'b0;
        for (int i = 0; i < NSTG; i++) begin
            if (int'(w_lat) - 1 == i) w_occ = r_stage[i].valid;
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        for (int i = 0; i < NSTG - 1; i++) w_next[i] = r_stage[i + 1];
        w_next[NSTG-1] = '0;
        o_bcast        = r_stage[0];
        o_collide      = 1'b0;
        if (i_flush) begin
            for (int i = 0; i < NSTG; i++) w_next[i] = '0;
        end else if (i_wk_v) begin
            if (w_occ) begin
                o_collide = 1'b1;
            end else if (w_lat == LAT_W'(1)) begin
                o_bcast = '{valid: 1'b1, tag: i_wk_prd};
            end else begin
                for (int i = 0; i < NSTG; i++) begin
                    if (int'(w_lat) - 2 == i) w_next[i] = '{valid: 1'b1, tag: i_wk_prd};
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) r_stage[i] <= '0;
        end else begin
            for (int i = 0; i < NSTG; i++) r_stage[i] <= w_next[i];
        end
    end

endmodule

// File: rtl/wakeup_ready_table.sv
// Registered per-entry source-ready tracker for one issue queue, fed by delayed
// per-port wakeup broadcasts and snooping those broadcasts at dispatch.
module wakeup_ready_table
    import wake_pkg::*;
#(
    parameter int ISSUE_NUM    = 4,
    parameter int DISPATCH_NUM = 4,
    parameter int PRF_WIDTH    = WK_PRF_WIDTH,
    parameter int CIQ_DEPTH    = 16,
    parameter int MAX_LAT      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wakeup_ready_table_if.slave  bus
);
    localparam int LAT_W = lat_width(MAX_LAT);

    wk_tag_t                 w_bcast [ISSUE_NUM];
    logic [ISSUE_NUM-1:0]    w_collide;
    logic [DISPATCH_NUM-1:0] w_snoop1, w_snoop2;

    logic [CIQ_DEPTH-1:0]    r_valid, r_rdy1, r_rdy2;
    logic [PRF_WIDTH-1:0]    r_prs1 [CIQ_DEPTH];
    logic [PRF_WIDTH-1:0]    r_prs2 [CIQ_DEPTH];
    logic                    r_collide;

    logic [CIQ_DEPTH-1:0]    w_valid_n, w_rdy1_n, w_rdy2_n;
    logic [PRF_WIDTH-1:0]    w_prs1_n [CIQ_DEPTH];
    logic [PRF_WIDTH-1:0]    w_prs2_n [CIQ_DEPTH];

    for (genvar p = 0; p < ISSUE_NUM; p++) begin : g_port
        wakeup_delay_line #(.MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) u_delay (
            .clk       (clk),
            .rst       (rst),
            .i_flush   (bus.flush),
            .i_wk_v    (bus.wk_v[p]),
            .i_wk_prd  (bus.wk_prd[p]),
            .i_wk_lat  (bus.wk_lat[p]),
            .o_bcast   (w_bcast[p]),
            .o_collide (w_collide[p])
        );
    end

    // Dispatch snoop: sources matching this cycle's broadcast set are born ready.
    always_comb begin
        w_snoop1 = '0;
        w_snoop2 = '0;
        for (int d = 0; d < DISPATCH_NUM; d++) begin
            for (int p = 0; p < ISSUE_NUM; p++) begin
                if (w_bcast[p].valid && w_bcast[p].tag != TAG_ZERO) begin
                    if (w_bcast[p].tag == bus.alloc_prs1[d]) w_snoop1[d] = 1'b1;
                    if (w_bcast[p].tag == bus.alloc_prs2[d]) w_snoop2[d] = 1'b1;
                end
            end
        end
    end

    // Per entry: alloc overrides ent_clr, which overrides wakeup; ascending port loop
    // lets the highest dispatch port win a duplicate index.
    always_comb begin
        w_valid_n = r_valid;
        w_rdy1_n  = r_rdy1;
        w_rdy2_n  = r_rdy2;
        w_prs1_n  = r_prs1;
        w_prs2_n  = r_prs2;
        for (int e = 0; e < CIQ_DEPTH; e++) begin
            if (bus.ent_clr[e]) begin
                w_valid_n[e] = 1'b0;
                w_rdy1_n[e]  = 1'b0;
                w_rdy2_n[e]  = 1'b0;
            end else if (r_valid[e]) begin
                for (int p = 0; p < ISSUE_NUM; p++) begin
                    if (w_bcast[p].valid && w_bcast[p].tag != TAG_ZERO) begin
                        if (w_bcast[p].tag == r_prs1[e]) w_rdy1_n[e] = 1'b1;
                        if (w_bcast[p].tag == r_prs2[e]) w_rdy2_n[e] = 1'b1;
                    end
                end
            end
        end
        for (int d = 0; d < DISPATCH_NUM; d++) begin
            if (bus.alloc_v[d] && !bus.flush) begin
                w_valid_n[bus.alloc_idx[d]] = 1'b1;
                w_prs1_n[bus.alloc_idx[d]]  = bus.alloc_prs1[d];
                w_prs2_n[bus.alloc_idx[d]]  = bus.alloc_prs2[d];
                w_rdy1_n[bus.alloc_idx[d]]  = bus.alloc_rdy1[d] | (bus.alloc_prs1[d] == TAG_ZERO) | w_snoop1[d];
                w_rdy2_n[bus.alloc_idx[d]]  = bus.alloc_rdy2[d] | (bus.alloc_prs2[d] == TAG_ZERO) | w_snoop2[d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= '0;
            r_rdy1    <= '0;
            r_rdy2    <= '0;
            r_collide <= 1'b0;
        end else if (bus.flush) begin
            r_valid   <= '0;
            r_rdy1    <= '0;
            r_rdy2    <= '0;
            r_collide <= 1'b0;
        end else begin
            r_valid   <= w_valid_n;
            r_rdy1    <= w_rdy1_n;
            r_rdy2    <= w_rdy2_n;
            r_collide <= |w_collide;
        end
    end

    // NOTE: tag storage is left unreset; it is only ever read under r_valid, which is reset.
    always_ff @(posedge clk) begin
        r_prs1 <= w_prs1_n;
        r_prs2 <= w_prs2_n;
    end

    assign bus.prs1_rdy   = r_rdy1;
    assign bus.prs2_rdy   = r_rdy2;
    assign bus.ent_rdy    = r_rdy1 & r_rdy2 & r_valid;
    assign bus.wk_collide = r_collide;

endmodule
